// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment scan decoder. The block debounces {control,display},
// decodes the tens and units digit slots, and publishes each new
// {tens,units} pair. A sequence check flags any pair that is not the BCD
// successor of the previously published pair.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic [3:0]  TENS_SEL      = 4'b0111,
  parameter logic [3:0]  UNITS_SEL     = 4'b1011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] display,
  input  logic [3:0] control,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       valid,
  output logic       seg_err,
  output logic       seq_err
);

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {EMPTY, GOT_T, GOT_U, EMIT} state_e;

  typedef struct packed {
    logic       ok;
    logic [3:0] value;
  } digit_t;

  // Hex 7-segment pattern {a..g} to digit value; ok=0 for unknown patterns.
  function automatic digit_t seg_decode(input logic [6:0] pat);
    digit_t d;
    d.ok    = 1'b1;
    d.value = 4'h0;
    case (pat)
      7'b1111110: d.value = 4'h0;
      7'b0110000: d.value = 4'h1;
      7'b1101101: d.value = 4'h2;
      7'b1111001: d.value = 4'h3;
      7'b0110011: d.value = 4'h4;
      7'b1011011: d.value = 4'h5;
      7'b1011111: d.value = 4'h6;
      7'b1110000: d.value = 4'h7;
      7'b1111111: d.value = 4'h8;
      7'b1111011: d.value = 4'h9;
      7'b1110111: d.value = 4'hA;
      7'b0011111: d.value = 4'hB;
      7'b1001110: d.value = 4'hC;
      7'b0111101: d.value = 4'hD;
      7'b1001111: d.value = 4'hE;
      7'b1000111: d.value = 4'hF;
      default:    d.ok    = 1'b0;
    endcase
    return d;
  endfunction

  // Input sampling / stability stage
  logic [11:0] in_w;
  logic [11:0] sample_d, sample_q;
  logic [7:0]  cnt_d, cnt_q;
  logic        same_w;
  logic        acc_d, acc_q;
  // Accepted frame without the dp bit: {control, a..g}
  logic [10:0] frame_d, frame_q;

  // Capture / publish stage
  state_e      state_d, state_q;
  logic [3:0]  pend_t_d, pend_t_q;
  logic [3:0]  pend_u_d, pend_u_q;
  logic [3:0]  tens_d, tens_q;
  logic [3:0]  units_d, units_q;
  logic        published_d, published_q;
  logic        valid_d, valid_q;
  logic        seg_err_d, seg_err_q;
  logic        seq_err_d, seq_err_q;

  digit_t      dec_w;
  logic        sel_t_w, sel_u_w, cap_t_w, cap_u_w;
  logic [3:0]  succ_t_w, succ_u_w;

  // Stability counter: accept a frame once, when its run first reaches STABLE_CYCLES
  always_comb begin
    // NOTE: every _d signal gets a default first so no path can infer a latch.
    in_w     = {control, display};
    same_w   = (in_w == sample_q);
    sample_d = in_w;
    cnt_d    = 8'd1;
    if (same_w) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
    // A saturated run equal to the threshold must not re-accept every cycle.
    acc_d   = (cnt_d == STABLE_W) && (!same_w || (cnt_q != STABLE_W));
    frame_d = acc_d ? {control, display[7:1]} : frame_q;
  end

  // Sample, run-length and accepted-frame registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q <= '0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      frame_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop sees pre-edge values.
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      frame_q  <= frame_d;
    end
  end

  // Decode the accepted frame and classify it as tens/units capture or error
  always_comb begin
    dec_w     = seg_decode(frame_q[6:0]);
    sel_t_w   = acc_q && (frame_q[10:7] == TENS_SEL);
    sel_u_w   = acc_q && (frame_q[10:7] == UNITS_SEL) && !sel_t_w;
    cap_t_w   = sel_t_w && dec_w.ok;
    cap_u_w   = sel_u_w && dec_w.ok;
    seg_err_d = (sel_t_w || sel_u_w) && !dec_w.ok;
  end

  // BCD modulo-100 successor of the last published pair
  always_comb begin
    succ_t_w = tens_q;
    succ_u_w = units_q + 4'd1;
    if (units_q >= 4'd9) begin
      succ_u_w = 4'd0;
      succ_t_w = (tens_q >= 4'd9) ? 4'd0 : tens_q + 4'd1;
    end
  end

  // Capture FSM next state, pending digits and publication outputs
  always_comb begin
    state_d     = state_q;
    pend_t_d    = pend_t_q;
    pend_u_d    = pend_u_q;
    tens_d      = tens_q;
    units_d     = units_q;
    published_d = published_q;
    valid_d     = 1'b0;
    seq_err_d   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (cap_t_w) begin
          pend_t_d = dec_w.value;
          state_d  = GOT_T;
        end else if (cap_u_w) begin
          pend_u_d = dec_w.value;
          state_d  = GOT_U;
        end
      end
      GOT_T: begin
        if (cap_t_w) begin
          pend_t_d = dec_w.value;
        end else if (cap_u_w) begin
          pend_u_d = dec_w.value;
          state_d  = EMIT;
        end
      end
      GOT_U: begin
        if (cap_u_w) begin
          pend_u_d = dec_w.value;
        end else if (cap_t_w) begin
          pend_t_d = dec_w.value;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        state_d = EMPTY;
        if (!published_q || ({pend_t_q, pend_u_q} != {tens_q, units_q})) begin
          tens_d      = pend_t_q;
          units_d     = pend_u_q;
          valid_d     = 1'b1;
          published_d = 1'b1;
          seq_err_d   = published_q &&
                        (({pend_t_q, pend_u_q} != {succ_t_w, succ_u_w}) ||
                         (pend_t_q > 4'd9) || (pend_u_q > 4'd9));
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // FSM, pending-digit and published-output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      pend_t_q    <= '0;
      pend_u_q    <= '0;
      tens_q      <= '0;
      units_q     <= '0;
      published_q <= 1'b0;
      valid_q     <= 1'b0;
      seg_err_q   <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_t_q    <= pend_t_d;
      pend_u_q    <= pend_u_d;
      tens_q      <= tens_d;
      units_q     <= units_d;
      published_q <= published_d;
      valid_q     <= valid_d;
      seg_err_q   <= seg_err_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign tens    = tens_q;
  assign units   = units_q;
  assign valid   = valid_q;
  assign seg_err = seg_err_q;
  assign seq_err = seq_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scan sequences, a behavioural
// run-length/pair model compared against the outputs every cycle, and
// literal expectations after each scenario.
module tb_seg_scan_decoder;

  localparam int         STABLE = 4;
  localparam logic [3:0] T_SEL  = 4'b0111;
  localparam logic [3:0] U_SEL  = 4'b1011;
  localparam logic [3:0] IDLE   = 4'b1111;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] display;
  logic [3:0] control;
  logic [3:0] tens, units;
  logic       valid, seg_err, seq_err;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_seg    = 0;
  int n_seq    = 0;
  int cyc      = 0;

  seg_scan_decoder #(
    .STABLE_CYCLES(STABLE),
    .TENS_SEL     (T_SEL),
    .UNITS_SEL    (U_SEL)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .display(display),
    .control(control),
    .tens   (tens),
    .units  (units),
    .valid  (valid),
    .seg_err(seg_err),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] seg(input int d);
    logic [6:0] p;
    p = SEG_TBL[d];
    return {p, 1'b0};
  endfunction

  // ---------------- behavioural model ----------------
  logic [11:0] prev_in, m_frame, in_now;
  bit          have_prev, frame_due, pub_due, have_t, have_u, m_pub, emit_now;
  int          run, cur_t, cur_u, pub_t, pub_u, last_t, last_u, idx;
  bit          exp_valid, exp_seg, exp_seq;

  always @(posedge clk) begin
    cyc++;
    in_now    = {control, display};
    exp_valid = 1'b0;
    exp_seg   = 1'b0;
    exp_seq   = 1'b0;
    if (!reset) begin
      have_prev = 0; run = 0; frame_due = 0; pub_due = 0;
      have_t = 0; have_u = 0; m_pub = 0; last_t = 0; last_u = 0;
    end else begin
      // Publication of a pair completed one edge earlier
      emit_now = pub_due;
      if (pub_due) begin
        pub_due = 0;
        if (!m_pub || pub_t != last_t || pub_u != last_u) begin
          exp_valid = 1'b1;
          exp_seq   = m_pub && ((pub_t > 9) || (pub_u > 9) ||
                      (pub_t * 10 + pub_u != (last_t * 10 + last_u + 1) % 100));
          last_t = pub_t;
          last_u = pub_u;
          m_pub  = 1;
        end
      end
      // Decode of a frame accepted one edge earlier
      if (frame_due) begin
        frame_due = 0;
        if (m_frame[11:8] == T_SEL || m_frame[11:8] == U_SEL) begin
          idx = -1;
          for (int i = 0; i < 16; i++) if (SEG_TBL[i] == m_frame[7:1]) idx = i;
          if (idx < 0) exp_seg = 1'b1;
          else if (!emit_now) begin
            if (m_frame[11:8] == T_SEL) begin cur_t = idx; have_t = 1; end
            else begin cur_u = idx; have_u = 1; end
            if (have_t && have_u) begin
              pub_t = cur_t; pub_u = cur_u; pub_due = 1;
              have_t = 0; have_u = 0;
            end
          end
        end
      end
      // Run length of identical samples; accept when it first hits STABLE
      if (have_prev && in_now == prev_in) run = (run < 255) ? run + 1 : 255;
      else run = 1;
      prev_in   = in_now;
      have_prev = 1;
      if (run == STABLE) begin
        frame_due = 1;
        m_frame   = in_now;
      end
    end
    #1;
    check("outputs", {5'd0, tens, units, valid, seg_err, seq_err},
          {5'd0, 4'(last_t), 4'(last_u), exp_valid, exp_seg, exp_seq});
    if (valid)   n_valid++;
    if (seg_err) n_seg++;
    if (seq_err) n_seq++;
  end

  // ---------------- stimulus ----------------
  task automatic scan(input logic [3:0] c, input logic [7:0] d, input int n);
    control = c;
    display = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic pair(input int t, input int u);
    scan(T_SEL, seg(t), 10);
    scan(U_SEL, seg(u), 10);
    scan(IDLE, 8'h00, 4);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  int v0, s0, q0;

  task automatic mark();
    v0 = n_valid; s0 = n_seg; q0 = n_seq;
  endtask

  initial begin
    reset   = 1'b0;
    control = IDLE;
    display = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", {5'd0, tens, units, valid, seg_err, seq_err}, 16'h0000);
    reset = 1'b1;

    // Tens 3 then units 7, first publication after reset
    mark();
    scan(T_SEL, 8'b11110010, 10);
    scan(U_SEL, 8'b11100000, 10);
    scan(IDLE, 8'h00, 4);
    check("first_pair_valid_cnt", 16'(n_valid - v0), 16'd1);
    check("first_pair_digits", {8'd0, tens, units}, 16'h0037);
    check("first_pair_seq_cnt", 16'(n_seq - q0), 16'd0);

    // 09 -> 10 in sequence, then 12 out of sequence
    pair(0, 9);
    mark();
    pair(1, 0);
    check("succ_10_valid_cnt", 16'(n_valid - v0), 16'd1);
    check("succ_10_seq_cnt", 16'(n_seq - q0), 16'd0);
    mark();
    pair(1, 2);
    check("skip_12_valid_cnt", 16'(n_valid - v0), 16'd1);
    check("skip_12_seq_cnt", 16'(n_seq - q0), 16'd1);
    check("skip_12_digits", {8'd0, tens, units}, 16'h0012);

    // 99 wraps to 00
    pair(9, 9);
    mark();
    pair(0, 0);
    check("wrap_valid_cnt", 16'(n_valid - v0), 16'd1);
    check("wrap_seq_cnt", 16'(n_seq - q0), 16'd0);
    check("wrap_digits", {8'd0, tens, units}, 16'h0000);

    // Glitch shorter than STABLE inside the tens slot
    mark();
    scan(T_SEL, seg(5), 2);
    scan(T_SEL, seg(8), 3);
    scan(T_SEL, seg(5), 10);
    scan(U_SEL, seg(6), 10);
    scan(IDLE, 8'h00, 4);
    check("glitch_digits", {8'd0, tens, units}, 16'h0056);
    check("glitch_valid_cnt", 16'(n_valid - v0), 16'd1);

    // Undecodable pattern held exactly STABLE cycles
    mark();
    scan(T_SEL, 8'b00000010, STABLE);
    scan(IDLE, 8'h00, 4);
    check("bad_seg_cnt", 16'(n_seg - s0), 16'd1);
    check("bad_seg_valid_cnt", 16'(n_valid - v0), 16'd0);

    // Repeat tens capture overwrites the pending tens digit
    scan(T_SEL, seg(1), 10);
    scan(T_SEL, seg(2), 10);
    scan(U_SEL, seg(3), 10);
    scan(IDLE, 8'h00, 4);
    check("overwrite_digits", {8'd0, tens, units}, 16'h0023);

    // Hex digit is published but flagged
    mark();
    pair(2, 10);
    check("hex_digits", {8'd0, tens, units}, 16'h002A);
    check("hex_seq_cnt", 16'(n_seq - q0), 16'd1);

    // Reset after tens capture discards it; next pair is a first publication
    scan(T_SEL, seg(8), 10);
    do_reset();
    mark();
    pair(4, 2);
    check("post_reset_digits", {8'd0, tens, units}, 16'h0042);
    check("post_reset_valid_cnt", 16'(n_valid - v0), 16'd1);
    check("post_reset_seq_cnt", 16'(n_seq - q0), 16'd0);

    // Same scan held for 100 cycles publishes once
    mark();
    for (int r = 0; r < 5; r++) begin
      scan(T_SEL, seg(6), 10);
      scan(U_SEL, seg(7), 10);
    end
    check("hold_valid_cnt", 16'(n_valid - v0), 16'd1);
    check("hold_digits", {8'd0, tens, units}, 16'h0067);

    // Unselected control frames are ignored, even with bad patterns
    mark();
    scan(IDLE, seg(3), 10);
    scan(IDLE, 8'b00000010, 10);
    check("idle_valid_cnt", 16'(n_valid - v0), 16'd0);
    check("idle_seg_cnt", 16'(n_seg - s0), 16'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
